wb_mem_arbiter: RTL and testbench

WB_MEM_ARBITER -- requirements
Module: wb_mem_arbiter

---
 rtl/wb_mem_arbiter_pkg.sv | 19 +
 rtl/wb_arb_wdog.sv | 36 +++
 rtl/wb_mem_arbiter.sv | 121 ++++++++++++
 tb/tb_wb_mem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_mem_arbiter_pkg
// Brief    : Shared constants for the two-master Wishbone memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package wb_mem_arbiter_pkg;

    localparam logic [1:0]  c_IDLE            = 2'd0;
    localparam logic [1:0]  c_OWN0            = 2'd1;
    localparam logic [1:0]  c_OWN1            = 2'd2;

    localparam int          c_TIMEOUT_DEFAULT = 64;
    localparam logic [15:0] c_TIMEOUT_DATA    = 16'hFFFF;
    // Wide enough for TIMEOUT-1 with TIMEOUT up to 127.
    localparam int          c_WDOG_W          = 7;

endpackage
`default_nettype wire

// File: rtl/wb_arb_wdog.sv
`default_nettype none
// ============================================================================
// Module   : wb_arb_wdog
// Brief    : Slave-stall counter and forced-termination compare.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arb_wdog
    import wb_mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = c_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_own,
    input  logic i_stb,
    input  logic i_ack,
    output logic o_expire
);

    localparam logic [c_WDOG_W-1:0] c_LIMIT = c_WDOG_W'(TIMEOUT - 1);

    logic [c_WDOG_W-1:0] r_cnt;

    // A coincident slave ack always beats the timeout.
    assign o_expire = i_own & i_stb & ~i_ack & (r_cnt == c_LIMIT);

    always_ff @(posedge clk) begin
        if (rst || !i_own || i_ack || o_expire) begin
            r_cnt <= '0;
        end else if (i_stb) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_mem_arbiter
// Brief    : Round-robin arbiter giving two Wishbone masters one memory slave.
// Revision : 1.0 - initial release
// ============================================================================
module wb_mem_arbiter
    import wb_mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = c_TIMEOUT_DEFAULT
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [18:0] m0_adr_i,
    input  logic [15:0] m0_dat_i,
    output logic [15:0] m0_dat_o,
    input  logic        m0_we_i,
    input  logic [1:0]  m0_sel_i,
    input  logic        m0_stb_i,
    input  logic        m0_cyc_i,
    output logic        m0_ack_o,
    input  logic [18:0] m1_adr_i,
    input  logic [15:0] m1_dat_i,
    output logic [15:0] m1_dat_o,
    input  logic        m1_we_i,
    input  logic [1:0]  m1_sel_i,
    input  logic        m1_stb_i,
    input  logic        m1_cyc_i,
    output logic        m1_ack_o,
    output logic [18:0] s_adr_o,
    output logic [15:0] s_dat_o,
    input  logic [15:0] s_dat_i,
    output logic        s_we_o,
    output logic [1:0]  s_sel_o,
    output logic        s_stb_o,
    output logic        s_cyc_o,
    input  logic        s_ack_i,
    output logic        timeout_o
);

    logic [1:0] r_state;
    logic       r_last;
    logic       w_req0;
    logic       w_req1;
    logic       w_own0;
    logic       w_own1;
    logic       w_own_stb;
    logic       w_expire;

    assign w_req0    = m0_cyc_i & m0_stb_i;
    assign w_req1    = m1_cyc_i & m1_stb_i;
    // Ownership is masked by reset so an in-flight transfer never acks.
    assign w_own0    = (r_state == c_OWN0) & ~wb_rst_i;
    assign w_own1    = (r_state == c_OWN1) & ~wb_rst_i;
    assign w_own_stb = (w_own0 & m0_stb_i) | (w_own1 & m1_stb_i);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= c_IDLE;
            r_last  <= 1'b1;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_req0 && (!w_req1 || r_last)) begin
                        r_state <= c_OWN0;
                        r_last  <= 1'b0;
                    end else if (w_req1) begin
                        r_state <= c_OWN1;
                        r_last  <= 1'b1;
                    end
                end
                c_OWN0:  if (!m0_cyc_i) r_state <= c_IDLE;
                c_OWN1:  if (!m1_cyc_i) r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    wb_arb_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .i_own    (w_own0 | w_own1),
        .i_stb    (w_own_stb),
        .i_ack    (s_ack_i),
        .o_expire (w_expire)
    );

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        if (w_own0) begin
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_we_o  = m0_we_i;
            s_sel_o = m0_sel_i;
            s_cyc_o = m0_cyc_i;
            s_stb_o = m0_stb_i & ~w_expire;
        end else if (w_own1) begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_we_o  = m1_we_i;
            s_sel_o = m1_sel_i;
            s_cyc_o = m1_cyc_i;
            s_stb_o = m1_stb_i & ~w_expire;
        end
    end

    assign m0_ack_o  = w_own0 & m0_stb_i & (s_ack_i | w_expire);
    assign m1_ack_o  = w_own1 & m1_stb_i & (s_ack_i | w_expire);
    assign m0_dat_o  = (w_own0 & w_expire) ? c_TIMEOUT_DATA : s_dat_i;
    assign m1_dat_o  = (w_own1 & w_expire) ? c_TIMEOUT_DATA : s_dat_i;
    assign timeout_o = w_expire;

endmodule
`default_nettype wire

// File: tb/tb_wb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_mem_arbiter
// Brief    : Directed + randomized bench for wb_mem_arbiter with reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_mem_arbiter;

    localparam int TO = 8;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic [18:0] adr  [2];
    logic [15:0] wdat [2];
    logic        we   [2];
    logic [1:0]  sel  [2];
    logic        stb  [2];
    logic        cyc  [2];
    logic        s_ack;
    logic [15:0] s_rdat;

    logic [15:0] m0_dat_o, m1_dat_o, s_dat_o;
    logic        m0_ack_o, m1_ack_o, s_we_o, s_stb_o, s_cyc_o, timeout_o;
    logic [18:0] s_adr_o;
    logic [1:0]  s_sel_o;

    always #5 wb_clk_i = ~wb_clk_i;

    wb_mem_arbiter #(.TIMEOUT(TO)) dut (
        .wb_clk_i (wb_clk_i),  .wb_rst_i (wb_rst_i),
        .m0_adr_i (adr[0]),    .m0_dat_i (wdat[0]),  .m0_dat_o (m0_dat_o),
        .m0_we_i  (we[0]),     .m0_sel_i (sel[0]),   .m0_stb_i (stb[0]),
        .m0_cyc_i (cyc[0]),    .m0_ack_o (m0_ack_o),
        .m1_adr_i (adr[1]),    .m1_dat_i (wdat[1]),  .m1_dat_o (m1_dat_o),
        .m1_we_i  (we[1]),     .m1_sel_i (sel[1]),   .m1_stb_i (stb[1]),
        .m1_cyc_i (cyc[1]),    .m1_ack_o (m1_ack_o),
        .s_adr_o  (s_adr_o),   .s_dat_o  (s_dat_o),  .s_dat_i  (s_rdat),
        .s_we_o   (s_we_o),    .s_sel_o  (s_sel_o),  .s_stb_o  (s_stb_o),
        .s_cyc_o  (s_cyc_o),   .s_ack_i  (s_ack),    .timeout_o(timeout_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who owns the slave (-1 = nobody), who wins the next
    // tie, and how many consecutive unanswered strobe cycles the owner has seen.
    int   owner   = -1;
    int   tie_win = 0;
    int   stall   = 0;
    logic ex_forced;
    logic ex_ack [2];

    logic        sn_stb, sn_cyc, sn_m0_ack, sn_m1_ack, sn_tmo;
    logic [15:0] sn_m0_dat;
    logic [18:0] sn_adr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare();
        int o;
        bit own;
        own = (owner >= 0);
        o   = own ? owner : 0;
        ex_forced = own && stb[o] && !s_ack && (stall == TO - 1);
        ex_ack[0] = own && (o == 0) && stb[0] && (s_ack || ex_forced);
        ex_ack[1] = own && (o == 1) && stb[1] && (s_ack || ex_forced);
        chk("s_stb",   s_stb_o,   own && stb[o] && !ex_forced);
        chk("s_cyc",   s_cyc_o,   own && cyc[o]);
        chk("s_we",    s_we_o,    own && we[o]);
        chk("s_adr",   s_adr_o,   own ? adr[o]  : 19'h0);
        chk("s_dat",   s_dat_o,   own ? wdat[o] : 16'h0);
        chk("s_sel",   s_sel_o,   own ? sel[o]  : 2'h0);
        chk("m0_ack",  m0_ack_o,  ex_ack[0]);
        chk("m1_ack",  m1_ack_o,  ex_ack[1]);
        chk("timeout", timeout_o, ex_forced);
        chk("m0_dat",  m0_dat_o,  (ex_forced && o == 0) ? 16'hFFFF : s_rdat);
        chk("m1_dat",  m1_dat_o,  (ex_forced && o == 1) ? 16'hFFFF : s_rdat);
    endtask

    task automatic advance();
        bit r0, r1;
        if (wb_rst_i) begin
            owner = -1; tie_win = 0; stall = 0;
        end else if (owner < 0) begin
            r0 = cyc[0] && stb[0];
            r1 = cyc[1] && stb[1];
            stall = 0;
            if (r0 && r1)  owner = tie_win;
            else if (r0)   owner = 0;
            else if (r1)   owner = 1;
            if (owner >= 0) tie_win = 1 - owner;
        end else begin
            if (s_ack || ex_forced) stall = 0;
            else if (stb[owner])    stall++;
            if (!cyc[owner]) begin
                owner = -1; stall = 0;
            end
        end
    endtask

    task automatic tick();
        @(negedge wb_clk_i);
        sn_stb = s_stb_o; sn_cyc = s_cyc_o; sn_m0_ack = m0_ack_o; sn_m1_ack = m1_ack_o;
        sn_tmo = timeout_o; sn_m0_dat = m0_dat_o; sn_adr = s_adr_o;
        if (!wb_rst_i) compare();
        else begin ex_ack[0] = 1'b0; ex_ack[1] = 1'b0; ex_forced = 1'b0; end
        @(posedge wb_clk_i);
        advance();
        #1;
    endtask

    task automatic req(input int n, input logic [18:0] a, input logic w);
        cyc[n] = 1'b1; stb[n] = 1'b1; adr[n] = a; we[n] = w;
        wdat[n] = 16'($urandom); sel[n] = 2'($urandom);
    endtask

    task automatic drop(input int n);
        cyc[n] = 1'b0; stb[n] = 1'b0;
    endtask

    task automatic rand_masters();
        for (int n = 0; n < 2; n++) begin
            if (!cyc[n]) begin
                if ($urandom_range(2) == 0) req(n, 19'($urandom), 1'($urandom));
            end else if (ex_ack[n] || !stb[n]) begin
                case ($urandom_range(2))
                    0:       drop(n);
                    1:       req(n, 19'($urandom), 1'($urandom));
                    default: stb[n] = 1'b0;
                endcase
            end
        end
    endtask

    localparam logic [18:0] A0 = 19'h11111;
    localparam logic [18:0] A1 = 19'h22222;

    initial begin
        for (int n = 0; n < 2; n++) begin
            adr[n] = '0; wdat[n] = '0; we[n] = 1'b0; sel[n] = '0;
            stb[n] = 1'b0; cyc[n] = 1'b0; ex_ack[n] = 1'b0;
        end
        s_ack = 1'b0; s_rdat = 16'h0; ex_forced = 1'b0;
        wb_rst_i = 1'b1;
        tick(); tick();
        wb_rst_i = 1'b0;
        tick();
        chk("rst_stb", sn_stb, 1'b0);
        chk("rst_cyc", sn_cyc, 1'b0);
        chk("rst_tmo", sn_tmo, 1'b0);

        // Single read from byte address 0x01000, slave answers after 2 waits.
        req(0, 19'h00800, 1'b0);
        tick(); chk("d1_lat0", sn_stb, 1'b0);
        tick(); chk("d1_lat1", sn_stb, 1'b1);
        tick();
        s_ack = 1'b1; s_rdat = 16'hBEEF;
        tick();
        chk("d1_ack", sn_m0_ack, 1'b1);
        chk("d1_dat", sn_m0_dat, 16'hBEEF);
        chk("d1_m1ack", sn_m1_ack, 1'b0);
        s_ack = 1'b0; drop(0);
        tick(); tick();

        // Ties after reset: m0, then m1, then m0 again.
        wb_rst_i = 1'b1; tick(); wb_rst_i = 1'b0;
        req(0, A0, 1'b1); req(1, A1, 1'b0);
        tick();
        s_ack = 1'b1;
        tick();
        chk("d2_first", sn_adr, A0);
        chk("d2_first_ack", sn_m0_ack, 1'b1);
        chk("d2_first_m1", sn_m1_ack, 1'b0);
        drop(0); s_ack = 1'b0;
        tick(); tick();
        s_ack = 1'b1;
        tick();
        chk("d2_second", sn_adr, A1);
        chk("d2_second_ack", sn_m1_ack, 1'b1);
        drop(1); s_ack = 1'b0;
        tick();
        req(0, A0, 1'b0); req(1, A1, 1'b0);
        tick();
        s_ack = 1'b1;
        tick();
        chk("d2_third", sn_adr, A0);
        drop(0); s_ack = 1'b0;
        tick();
        drop(1);
        tick();

        // m0 keeps cyc over three strobes while m1 waits.
        req(0, A0, 1'b0);
        tick();
        req(1, A1, 1'b1); s_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            adr[0] = 19'h00100 + 19'(i);
            tick();
            chk("d3_hold", sn_adr, 19'h00100 + 19'(i));
            chk("d3_m1wait", sn_m1_ack, 1'b0);
        end
        drop(0); s_ack = 1'b0;
        tick(); chk("d3_drop", sn_stb, 1'b0);
        tick(); chk("d3_idle", sn_cyc, 1'b0);
        s_ack = 1'b1;
        tick();
        chk("d3_m1", sn_adr, A1);
        chk("d3_m1ack", sn_m1_ack, 1'b1);
        drop(1); s_ack = 1'b0;
        tick(); tick();

        // Slave never answers: forced termination on the 8th stalled cycle.
        req(0, A0, 1'b0);
        tick();
        for (int i = 0; i < TO - 1; i++) begin
            tick(); chk("d4_noto", sn_tmo, 1'b0);
        end
        tick();
        chk("d4_to", sn_tmo, 1'b1);
        chk("d4_ack", sn_m0_ack, 1'b1);
        chk("d4_dat", sn_m0_dat, 16'hFFFF);
        chk("d4_stb", sn_stb, 1'b0);
        drop(0);
        tick(); tick(); chk("d4_idle", sn_cyc, 1'b0);

        // Ack lands exactly on the last stall cycle: normal completion wins.
        req(0, A0, 1'b0);
        tick();
        for (int i = 0; i < TO - 1; i++) tick();
        s_ack = 1'b1; s_rdat = 16'h1234;
        tick();
        chk("d5_noto", sn_tmo, 1'b0);
        chk("d5_dat", sn_m0_dat, 16'h1234);
        chk("d5_ack", sn_m0_ack, 1'b1);
        s_ack = 1'b0; drop(0);
        tick(); tick();

        // Reset in the middle of a stall abandons the transfer.
        req(1, A1, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) tick();
        wb_rst_i = 1'b1; s_ack = 1'b1;
        tick();
        chk("d6_rst_ack", sn_m1_ack, 1'b0);
        wb_rst_i = 1'b0; s_ack = 1'b0;
        tick();
        chk("d6_stb", sn_stb, 1'b0);
        chk("d6_cyc", sn_cyc, 1'b0);
        chk("d6_ack", sn_m1_ack, 1'b0);
        drop(1);
        tick(); tick();

        // Random traffic with decreasing slave responsiveness.
        for (int ph = 0; ph < 4; ph++) begin
            for (int c = 0; c < 800; c++) begin
                rand_masters();
                case (ph)
                    0:       s_ack = ($urandom_range(1) == 0);
                    1:       s_ack = ($urandom_range(3) == 0);
                    2:       s_ack = ($urandom_range(9) == 0);
                    default: s_ack = 1'b0;
                endcase
                s_rdat   = 16'($urandom);
                wb_rst_i = ($urandom_range(499) == 0);
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
